// File: rtl/shift_rotate_chain.sv
// Shift/rotate register chain: DEPTH stages of WIDTH-bit data, each with a
// valid bit. It supports hold, shift, broadcast and rotate modes, a parallel
// load, a rotation-wrap pulse and a registered occupancy count.

package shift_rotate_chain_pkg;
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_BCAST = 2'b10,
        MODE_ROT   = 2'b11
    } mode_t;
endpackage

// One chain stage. The parent supplies the shift source and the rotate
// source, so stage 0 can take din on a shift and the last stage on a rotate.
// The next-state valid bit is exported so the parent can register occupancy
// on the same edge as the valid bits.
module shift_rotate_stage
    import shift_rotate_chain_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] shift_val,
    input  logic             shift_vld,
    input  logic [WIDTH-1:0] rot_val,
    input  logic             rot_vld,
    output logic [WIDTH-1:0] q,
    output logic             vld,
    output logic             nxt_vld
);

    logic [WIDTH-1:0] nxt_q;

    // Select the next stage value. Load wins over mode, and en=0 freezes the stage.
    always_comb begin
        nxt_q   = q;
        nxt_vld = vld;
        if (en) begin
            if (load) begin
                nxt_q   = load_val;
                nxt_vld = 1'b1;
            end else begin
                unique case (mode)
                    MODE_SHIFT: begin
                        nxt_q   = shift_val;
                        nxt_vld = shift_vld;
                    end
                    MODE_BCAST: begin
                        nxt_q   = din;
                        nxt_vld = din_valid;
                    end
                    MODE_ROT: begin
                        nxt_q   = rot_val;
                        nxt_vld = rot_vld;
                    end
                    default: begin
                        nxt_q   = q;
                        nxt_vld = vld;
                    end
                endcase
            end
        end
    end

    // Stage register. Reset restores the per-stage seed and clears valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= RST_VAL;
            vld <= 1'b0;
        end else begin
            q   <= nxt_q;
            vld <= nxt_vld;
        end
    end

endmodule

// Top level: an array of stages plus the rotation counter, the wrap pulse
// and the occupancy register.
module shift_rotate_chain
    import shift_rotate_chain_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 3,
    parameter int RESET_SEQ = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    input  logic                       load,
    input  logic [DEPTH*WIDTH-1:0]     load_data,
    output logic [DEPTH*WIDTH-1:0]     stages,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       rot_wrap
);

    localparam int CW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH-1);

    mode_t                        mode_e;
    logic [DEPTH-1:0][WIDTH-1:0]  q;
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0]             nxt_vld;
    logic [DEPTH-1:0][WIDTH-1:0]  ld;
    logic [CW-1:0]                rot_cnt, rot_cnt_nxt;
    logic                         wrap_nxt;
    logic [OW-1:0]                occ_nxt;

    assign mode_e = mode_t'(mode);
    assign ld     = load_data;

    // Every stage updates from pre-edge neighbour values. Stage 0 shifts in
    // din and rotates in the last stage.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        localparam logic [WIDTH-1:0] RV = (RESET_SEQ != 0) ? WIDTH'(i+1) : '0;
        localparam int PREV = (i == 0) ? DEPTH-1 : i-1;

        logic [WIDTH-1:0] shift_val;
        logic             shift_vld;

        if (i == 0) begin : g_head
            assign shift_val = din;
            assign shift_vld = din_valid;
        end else begin : g_body
            assign shift_val = q[PREV];
            assign shift_vld = vld[PREV];
        end

        shift_rotate_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RV)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .load      (load),
            .mode      (mode_e),
            .load_val  (ld[i]),
            .din       (din),
            .din_valid (din_valid),
            .shift_val (shift_val),
            .shift_vld (shift_vld),
            .rot_val   (q[PREV]),
            .rot_vld   (vld[PREV]),
            .q         (q[i]),
            .vld       (vld[i]),
            .nxt_vld   (nxt_vld[i])
        );
    end

    // The rotation counter advances on each rotate and clears on any other
    // enabled update. Wrap fires when it steps past the last stage.
    always_comb begin
        rot_cnt_nxt = rot_cnt;
        wrap_nxt    = 1'b0;
        if (en) begin
            if (!load && mode_e == MODE_ROT) begin
                if (rot_cnt == LAST) begin
                    rot_cnt_nxt = '0;
                    wrap_nxt    = 1'b1;
                end else begin
                    rot_cnt_nxt = rot_cnt + 1'b1;
                end
            end else begin
                rot_cnt_nxt = '0;
            end
        end
    end

    // Occupancy is the popcount of the valid bits being registered this
    // edge, so the registered count always matches the registered valids.
    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_nxt = occ_nxt + OW'(nxt_vld[i]);
    end

    // Chain-level control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_cnt   <= '0;
            rot_wrap  <= 1'b0;
            occupancy <= '0;
        end else begin
            rot_cnt   <= rot_cnt_nxt;
            rot_wrap  <= wrap_nxt;
            occupancy <= occ_nxt;
        end
    end

    assign stages     = q;
    assign dout       = q[DEPTH-1];
    assign dout_valid = vld[DEPTH-1];

endmodule

// File: tb/tb_shift_rotate_chain.sv
// Scoreboard bench for shift_rotate_chain. The driver applies one input
// vector per cycle on the falling edge and steps a queue-based reference
// model. The model's expected post-edge state goes into a scoreboard queue,
// and a monitor compares it with the DUT just after each rising edge.
module tb_shift_rotate_chain;

    localparam int W  = 32;
    localparam int D  = 3;
    localparam int OW = $clog2(D+1);

    typedef struct {
        logic [D*W-1:0] stages;
        logic [W-1:0]   dout;
        logic           dv;
        logic [OW-1:0]  occ;
        logic           wrap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [W-1:0]    din = '0;
    logic            din_valid = 1'b0;
    logic            load = 1'b0;
    logic [D*W-1:0]  load_data = '0;
    logic [D*W-1:0]  stages;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic [OW-1:0]   occupancy;
    logic            rot_wrap;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t sb[$];

    // Reference model: index 0 is stage 0.
    logic [W-1:0] mval[$];
    bit           mvld[$];
    int           mrot;
    bit           mwrap;

    shift_rotate_chain #(.WIDTH(W), .DEPTH(D), .RESET_SEQ(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .din        (din),
        .din_valid  (din_valid),
        .load       (load),
        .load_data  (load_data),
        .stages     (stages),
        .dout       (dout),
        .dout_valid (dout_valid),
        .occupancy  (occupancy),
        .rot_wrap   (rot_wrap)
    );

    always #5 clk = ~clk;

    function automatic void model_step(bit r, bit e, bit l, logic [1:0] m,
                                       logic [W-1:0] d, bit dvl, logic [D*W-1:0] ldv);
        logic [W-1:0] tv;
        bit           tb_v;
        if (r) begin
            mval.delete(); mvld.delete();
            for (int i = 0; i < D; i++) begin
                mval.push_back(W'(i+1));
                mvld.push_back(1'b0);
            end
            mrot = 0; mwrap = 0;
        end else if (!e) begin
            mwrap = 0;
        end else if (l) begin
            for (int i = 0; i < D; i++) begin
                mval[i] = ldv[i*W +: W];
                mvld[i] = 1'b1;
            end
            mrot = 0; mwrap = 0;
        end else begin
            mwrap = 0;
            case (m)
                2'b01: begin
                    mval.push_front(d);   void'(mval.pop_back());
                    mvld.push_front(dvl); void'(mvld.pop_back());
                    mrot = 0;
                end
                2'b10: begin
                    for (int i = 0; i < D; i++) begin
                        mval[i] = d;
                        mvld[i] = dvl;
                    end
                    mrot = 0;
                end
                2'b11: begin
                    tv = mval.pop_back();   mval.push_front(tv);
                    tb_v = mvld.pop_back(); mvld.push_front(tb_v);
                    mrot++;
                    if (mrot == D) begin
                        mrot = 0; mwrap = 1;
                    end
                end
                default: mrot = 0;
            endcase
        end
    endfunction

    function automatic exp_t model_snapshot();
        exp_t x;
        int   n = 0;
        for (int i = 0; i < D; i++) begin
            x.stages[i*W +: W] = mval[i];
            n += int'(mvld[i]);
        end
        x.dout = mval[D-1];
        x.dv   = mvld[D-1];
        x.occ  = OW'(n);
        x.wrap = mwrap;
        return x;
    endfunction

    task automatic drive(input bit r, input bit e, input bit l, input logic [1:0] m,
                         input logic [W-1:0] d, input bit dvl, input logic [D*W-1:0] ldv);
        @(negedge clk);
        rst = r; en = e; load = l; mode = m; din = d; din_valid = dvl; load_data = ldv;
        model_step(r, e, l, m, d, dvl, ldv);
        sb.push_back(model_snapshot());
    endtask

    function automatic void chk(string name, logic [D*W-1:0] got, logic [D*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endfunction

    // Monitor: compare the DUT with the oldest outstanding expectation after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stages",     stages,     e.stages);
                chk("dout",       dout,       e.dout);
                chk("dout_valid", dout_valid, e.dv);
                chk("occupancy",  occupancy,  e.occ);
                chk("rot_wrap",   rot_wrap,   e.wrap);
            end
        end
    end

    // Driver: directed scenarios first, then randomized traffic.
    initial begin
        logic [D*W-1:0] ld;
        logic [D*W-1:0] z;
        z  = '0;
        ld = {32'd30, 32'd20, 32'd10};

        // Reset, then one valid word shifted all the way to dout.
        drive(1, 0, 0, 2'b00, 0, 0, z);
        drive(0, 1, 0, 2'b01, 32'd7, 1, z);
        drive(0, 1, 0, 2'b01, 32'd0, 0, z);
        drive(0, 1, 0, 2'b01, 32'd0, 0, z);
        // Broadcast from reset values.
        drive(1, 0, 0, 2'b00, 0, 0, z);
        drive(0, 1, 0, 2'b10, 32'd2, 1, z);
        // Load (overriding broadcast), then a full rotation.
        drive(0, 1, 1, 2'b10, 32'hdead, 0, ld);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 2'b11, 32'hbeef, 0, z);
        // Rotate across an en=0 gap.
        drive(0, 1, 0, 2'b11, 0, 0, z);
        drive(0, 1, 0, 2'b11, 0, 0, z);
        drive(0, 0, 1, 2'b01, 32'h55, 1, ld);
        drive(0, 0, 0, 2'b10, 32'h66, 1, z);
        drive(0, 1, 0, 2'b11, 0, 0, z);
        // Reset during a rotation, then a rotate acting on reset values.
        drive(0, 1, 0, 2'b11, 0, 0, z);
        drive(1, 1, 1, 2'b11, 0, 0, ld);
        drive(0, 1, 0, 2'b11, 0, 0, z);
        // Alternating valid shift from reset.
        drive(1, 0, 0, 2'b00, 0, 0, z);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 2'b01, W'(100+i), (i % 2) == 0, z);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 8,
                  2'($urandom_range(0, 3)),
                  $urandom,
                  1'($urandom_range(0, 1)),
                  {$urandom, $urandom, $urandom});
        end
        drive(0, 0, 0, 2'b00, 0, 0, z);
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", D*W'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_rotate_chain.md
SHIFT_ROTATE_CHAIN -- requirements
Module: shift_rotate_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per stage.
REQ-002 SHALL have parameter DEPTH, default 3: number of register stages; legal range 2..16.
REQ-003 SHALL have parameter RESET_SEQ, default 1: 1 resets stage i to value i+1; 0 resets all stages to 0.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1: update enable; 0 freezes all state.
REQ-007 SHALL have port mode  input  2: 00 HOLD, 01 SHIFT, 10 BROADCAST, 11 ROTATE.
REQ-008 SHALL have port din  input  WIDTH: data entering stage 0.
REQ-009 SHALL have port din_valid  input  1: validity of din.
REQ-010 SHALL have port load  input  1: parallel load request.
REQ-011 SHALL have port load_data  input  DEPTH*WIDTH: stage i value at bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port stages  output  DEPTH*WIDTH: registered stage contents, same packing as load_data.
REQ-013 SHALL have port dout  output  WIDTH: equals stage DEPTH-1.
REQ-014 SHALL have port dout_valid  output  1: valid bit of stage DEPTH-1.
REQ-015 SHALL have port occupancy  output  clog2(DEPTH+1): count of set stage valid bits.
REQ-016 SHALL have port rot_wrap  output  1: one-cycle pulse when a full rotation completes.

Function
REQ-017 Each stage SHALL hold a WIDTH-bit value plus a valid bit; all outputs SHALL be driven directly from registers.
REQ-018 All stage updates SHALL use pre-edge values of every stage (non-blocking semantics); no stage sees another stage's same-cycle update.
REQ-019 en=0: stages, valid bits and rotation counter hold; rot_wrap=0; load and mode ignored.
REQ-020 en=1, load=1: stage i <= load_data slice i, all valid bits <= 1, rotation counter <= 0, regardless of mode.
REQ-021 en=1, load=0, HOLD: no change; rotation counter <= 0.
REQ-022 en=1, load=0, SHIFT: stage0 <= din, valid0 <= din_valid; stage i <= old stage i-1 and valid i <= old valid i-1, for i>=1; old stage DEPTH-1 discarded; din-to-dout latency DEPTH cycles.
REQ-023 en=1, load=0, BROADCAST: every stage <= din and every valid bit <= din_valid in one cycle; din-to-dout latency 1 cycle.
REQ-024 en=1, load=0, ROTATE: stage0 <= old stage DEPTH-1, stage i <= old stage i-1; valid bits rotate identically; din ignored; occupancy unchanged.
REQ-025 Rotation counter (0..DEPTH-1) SHALL increment on each ROTATE update and wrap to 0 after DEPTH-1; counter <= 0 on any non-ROTATE update (en=1).
REQ-026 rot_wrap SHALL be 1 in the cycle after a ROTATE update moves the counter from DEPTH-1 to 0, else 0; stages then equal their values before the first rotation.
REQ-027 occupancy SHALL equal the popcount of the valid bits registered at that edge, never exceeding DEPTH.
REQ-028 mode changes SHALL take effect on the same edge, with no pipeline flush and no lost stage contents.

Reset
REQ-029 rst=1 at a rising edge SHALL override en, load and mode: stage i <= (RESET_SEQ ? i+1 : 0), all valid bits <= 0, rotation counter <= 0, rot_wrap <= 0, occupancy <= 0.
REQ-030 Reset asserted mid-rotation or mid-shift SHALL discard all in-flight data; the first post-reset update SHALL act on reset values only.

Verification
REQ-031 DEPTH=3, RESET_SEQ=1, rst 1 cycle -> stages = {1,2,3} (stage0..2), dout=3, dout_valid=0, occupancy=0.
REQ-032 After REQ-031, SHIFT, din=7/valid=1 for 1 cycle -> stages={7,1,2}, valid={1,0,0}, occupancy=1; din=7 reaches dout after 3 SHIFT cycles, with dout_valid=1.
REQ-033 After REQ-031, BROADCAST, din=2/valid=1 for 1 cycle -> stages={2,2,2}, dout=2, dout_valid=1, occupancy=3.
REQ-034 load_data={10,20,30}, load=1 with mode=BROADCAST -> stages={10,20,30}, occupancy=3; then ROTATE 3 cycles -> {30,10,20}, {20,30,10}, {10,20,30}; rot_wrap=1 only after the third rotation.
REQ-035 ROTATE 2 cycles, en=0 for 2 cycles, then ROTATE 1 cycle -> stages frozen while en=0, rot_wrap=1 after the third ROTATE update; rst during the second rotation -> counter=0 and stages={1,2,3}.
REQ-036 SHIFT with din_valid alternating 1,0 for 6 cycles -> occupancy sequence 1,1,2,1,2,1; dout_valid follows din_valid delayed by 3 cycles.
